// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset core: sequences fetch, decode,
// execute, memory and write-back, and drives ALU and datapath controls.
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (bne handled in the BEQ state).
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       ALU_zero,
  input  logic       mem_ready,
  output logic [1:0] ALU_ctrl,
  output logic [1:0] ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [1:0] Result_src,
  output logic       Adr_src,
  output logic       IR_write,
  output logic       PC_write,
  output logic       Reg_write,
  output logic       Mem_write,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic       f3_alu_ok;
  logic       is_mem_ok;
  logic       branch_ok;
  logic       branch_take;
  logic [1:0] alu_op_dec;

  // Only add/and/or forms are implemented for register and immediate ALU ops.
  assign f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign is_mem_ok = ((op == OP_LOAD) || (op == OP_STORE)) && (funct3 == 3'b010);

`ifdef MULTICYCLE_CTRL_BNE_EN
  assign branch_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign branch_take = (funct3 == 3'b001) ? ~ALU_zero : ALU_zero;
`else
  assign branch_ok   = (funct3 == 3'b000);
  assign branch_take = ALU_zero;
`endif

  // Subtract only for R-type with funct7b5; addi ignores that bit.
  always_comb begin
    alu_op_dec = ALU_ADD;
    case (funct3)
      3'b111:  alu_op_dec = ALU_AND;
      3'b110:  alu_op_dec = ALU_OR;
      default: alu_op_dec = ((op == OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ALU_ctrl   = ALU_ADD;
    ALU_srcA   = SRCA_PC;
    ALU_srcB   = SRCB_REG;
    Result_src = RES_ALUOUT;
    Adr_src    = 1'b0;
    IR_write   = 1'b0;
    PC_write   = 1'b0;
    Reg_write  = 1'b0;
    Mem_write  = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      FETCH: begin
        ALU_srcA   = SRCA_PC;
        ALU_srcB   = SRCB_FOUR;
        ALU_ctrl   = ALU_ADD;
        Result_src = RES_ALU;
        IR_write   = mem_ready;
        PC_write   = mem_ready;
        if (mem_ready) state_next = DECODE;
      end

      DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ALU_srcA = SRCA_OLDPC;
        ALU_srcB = SRCB_IMM;
        ALU_ctrl = ALU_ADD;
        if (is_mem_ok) begin
          state_next = MEMADR;
        end else if ((op == OP_RTYPE) && f3_alu_ok) begin
          state_next = EXECUTER;
        end else if ((op == OP_ITYPE) && f3_alu_ok) begin
          state_next = EXECUTEI;
        end else if ((op == OP_BRANCH) && branch_ok) begin
          state_next = BEQ;
        end else if (op == OP_JAL) begin
          state_next = JAL;
        end else begin
          illegal    = 1'b1;
          state_next = FETCH;
        end
      end

      MEMADR: begin
        ALU_srcA   = SRCA_REG;
        ALU_srcB   = SRCB_IMM;
        ALU_ctrl   = ALU_ADD;
        state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end

      MEMREAD: begin
        Adr_src    = 1'b1;
        Result_src = RES_ALUOUT;
        if (mem_ready) state_next = MEMWB;
      end

      MEMWB: begin
        Result_src = RES_DATA;
        Reg_write  = 1'b1;
        state_next = FETCH;
      end

      MEMWRITE: begin
        Adr_src    = 1'b1;
        Result_src = RES_ALUOUT;
        Mem_write  = 1'b1;
        if (mem_ready) state_next = FETCH;
      end

      EXECUTER: begin
        ALU_srcA   = SRCA_REG;
        ALU_srcB   = SRCB_REG;
        ALU_ctrl   = alu_op_dec;
        state_next = ALUWB;
      end

      EXECUTEI: begin
        ALU_srcA   = SRCA_REG;
        ALU_srcB   = SRCB_IMM;
        ALU_ctrl   = alu_op_dec;
        state_next = ALUWB;
      end

      ALUWB: begin
        Result_src = RES_ALUOUT;
        Reg_write  = 1'b1;
        state_next = FETCH;
      end

      BEQ: begin
        ALU_srcA   = SRCA_REG;
        ALU_srcB   = SRCB_REG;
        ALU_ctrl   = ALU_SUB;
        Result_src = RES_ALUOUT;
        PC_write   = branch_take;
        state_next = FETCH;
      end

      JAL: begin
        // Jump target from ALUOut; PC+4 computed now for the rd write-back.
        ALU_srcA   = SRCA_OLDPC;
        ALU_srcB   = SRCB_FOUR;
        ALU_ctrl   = ALU_ADD;
        Result_src = RES_ALUOUT;
        PC_write   = 1'b1;
        state_next = ALUWB;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected output
// sequences are queued by the stimulus and checked by an independent monitor.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       ALU_zero;
  logic       mem_ready;
  logic [1:0] ALU_ctrl;
  logic [1:0] ALU_srcA;
  logic [1:0] ALU_srcB;
  logic [1:0] Result_src;
  logic       Adr_src;
  logic       IR_write;
  logic       PC_write;
  logic       Reg_write;
  logic       Mem_write;
  logic       illegal;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .ALU_zero(ALU_zero), .mem_ready(mem_ready), .ALU_ctrl(ALU_ctrl),
    .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB), .Result_src(Result_src),
    .Adr_src(Adr_src), .IR_write(IR_write), .PC_write(PC_write),
    .Reg_write(Reg_write), .Mem_write(Mem_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_BNE, K_JAL, K_ILL} kind_t;

  // {ctrl, srcA, srcB, Result_src, Adr_src, IR_write, PC_write, Reg_write, Mem_write, illegal}
  logic [13:0] dut_vec;
  assign dut_vec = {ALU_ctrl, ALU_srcA, ALU_srcB, Result_src, Adr_src,
                    IR_write, PC_write, Reg_write, Mem_write, illegal};

  logic [13:0] exp_q[$];
  string       name_q[$];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [13:0] mk(logic [1:0] c, logic [1:0] a, logic [1:0] b,
                                     logic [1:0] rs, logic adr, logic irw, logic pcw,
                                     logic rw, logic mw, logic ill);
    return {c, a, b, rs, adr, irw, pcw, rw, mw, ill};
  endfunction

  function automatic logic [13:0] fetch_vec(logic mr);
    return mk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, mr, mr, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic kind_t classify(logic [6:0] o, logic [2:0] f3);
    logic alu_f3;
    alu_f3 = (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
    if (o == OP_LOAD && f3 == 3'b010) return K_LW;
    if (o == OP_STORE && f3 == 3'b010) return K_SW;
    if (o == OP_RTYPE && alu_f3) return K_R;
    if (o == OP_ITYPE && alu_f3) return K_I;
    if (o == OP_BRANCH && f3 == 3'b000) return K_BEQ;
`ifdef MULTICYCLE_CTRL_BNE_EN
    if (o == OP_BRANCH && f3 == 3'b001) return K_BNE;
`endif
    if (o == OP_JAL) return K_JAL;
    return K_ILL;
  endfunction

  function automatic logic [1:0] alu_of(logic is_r, logic [2:0] f3, logic f7);
    if (f3 == 3'b111) return 2'b10;
    if (f3 == 3'b110) return 2'b11;
    return (is_r && f7) ? 2'b01 : 2'b00;
  endfunction

  task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, dut_vec, e);
    end
  end

  // Called just after a rising edge: drive one cycle of inputs and queue its expectation.
  task automatic step(input logic mr, input logic az, input logic [13:0] e, input string nm);
    mem_ready = mr;
    ALU_zero  = az;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw, input logic az);
    kind_t k;
    logic [1:0] c;
    k = classify(o, f3);
    c = alu_of(o == OP_RTYPE, f3, f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    for (int i = 0; i < fw; i++) step(1'b0, rb(), fetch_vec(1'b0), "fetch_wait");
    step(1'b1, rb(), fetch_vec(1'b1), "fetch");
    step(rb(), rb(), mk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        k == K_ILL), "decode");
    case (k)
      K_LW: begin
        step(rb(), rb(), mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "lw_memadr");
        for (int i = 0; i < mw; i++)
          step(1'b0, rb(), mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0), "lw_memread_wait");
        step(1'b1, rb(), mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0), "lw_memread");
        step(rb(), rb(), mk(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0), "lw_memwb");
      end
      K_SW: begin
        step(rb(), rb(), mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "sw_memadr");
        for (int i = 0; i < mw; i++)
          step(1'b0, rb(), mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0), "sw_memwrite_wait");
        step(1'b1, rb(), mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0), "sw_memwrite");
      end
      K_R: begin
        step(rb(), rb(), mk(c, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "executer");
        step(rb(), rb(), mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0), "r_aluwb");
      end
      K_I: begin
        step(rb(), rb(), mk(c, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "executei");
        step(rb(), rb(), mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0), "i_aluwb");
      end
      K_BEQ: step(rb(), az, mk(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, az, 0, 0, 0), "beq");
      K_BNE: step(rb(), az, mk(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, ~az, 0, 0, 0), "bne");
      K_JAL: begin
        step(rb(), rb(), mk(2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0), "jal");
        step(rb(), rb(), mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0), "jal_aluwb");
      end
      default: ;
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    op = 7'd0;
    funct3 = 3'd0;
    funct7b5 = 1'b0;
    ALU_zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // FETCH outputs presented while held in reset, gated by mem_ready.
    step(1'b0, 1'b0, fetch_vec(1'b0), "reset_fetch_mr0");
    step(1'b1, 1'b0, fetch_vec(1'b1), "reset_fetch_mr1");
    rst_n = 1'b1;

    run_instr(OP_RTYPE, 3'b000, 1'b0, 0, 0, 1'b0);   // add
    run_instr(OP_RTYPE, 3'b000, 1'b1, 0, 0, 1'b0);   // sub
    run_instr(OP_ITYPE, 3'b000, 1'b1, 1, 0, 1'b0);   // addi, f7b5 ignored
    run_instr(OP_ITYPE, 3'b110, 1'b0, 0, 0, 1'b0);   // ori
    run_instr(OP_ITYPE, 3'b111, 1'b0, 0, 0, 1'b0);   // andi
    run_instr(OP_LOAD, 3'b010, 1'b0, 0, 2, 1'b0);    // lw, 2 wait cycles
    run_instr(OP_STORE, 3'b010, 1'b0, 0, 2, 1'b0);   // sw
    run_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b1);  // beq taken
    run_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b0);  // beq not taken
    run_instr(OP_BRANCH, 3'b001, 1'b0, 0, 0, 1'b1);  // bne
    run_instr(OP_BRANCH, 3'b001, 1'b0, 0, 0, 1'b0);
    run_instr(OP_JAL, 3'b101, 1'b0, 0, 0, 1'b0);
    run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, 1'b0); // illegal opcode
    run_instr(OP_RTYPE, 3'b001, 1'b0, 0, 0, 1'b0);   // sll unsupported

    // Asynchronous reset while waiting in MEMWRITE.
    op = OP_STORE;
    funct3 = 3'b010;
    funct7b5 = 1'b0;
    step(1'b1, 1'b0, fetch_vec(1'b1), "ar_fetch");
    step(1'b0, 1'b0, mk(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "ar_decode");
    step(1'b0, 1'b0, mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "ar_memadr");
    mem_ready = 1'b0;
    exp_q.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0));
    name_q.push_back("ar_memwrite");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_in_memwrite", dut_vec, fetch_vec(1'b0));
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, fetch_vec(1'b1), "ar_held_fetch");
    rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      logic [2:0] f3;
      int sel;
      sel = int'($urandom_range(0, 9));
      f3 = 3'($urandom_range(0, 7));
      case (sel)
        0: begin o = OP_LOAD;   if (rb()) f3 = 3'b010; end
        1: begin o = OP_STORE;  if (rb()) f3 = 3'b010; end
        2: begin o = OP_RTYPE;  if (rb()) f3 = {f3[2:1] == 2'b11 ? f3[2:1] : 2'b00, f3[0] & f3[1]}; end
        3: begin o = OP_ITYPE;  if (rb()) f3 = 3'b000; end
        4: begin o = OP_BRANCH; f3 = {2'b00, f3[0]}; end
        5: o = OP_BRANCH;
        6: o = OP_JAL;
        7: o = 7'($urandom_range(0, 127));
        8: begin o = OP_RTYPE; f3 = rb() ? 3'b110 : 3'b111; end
        default: begin o = OP_ITYPE; f3 = rb() ? 3'b110 : 3'b111; end
      endcase
      run_instr(o, f3, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb());
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
